fp_mult_result_fifo: RTL and testbench

Downstream stage of `fp_mult_top`: captures each `(z, status)` pair the multiplier produces into a DEPTH-entry result FIFO and presents it to a consumer over a valid/ready handshake. It also keeps an accepted-result counter and a sticky drop flag. When configured, it accumulates the IEEE exception flags across results. This block decouples the multiplier's fixed-rate output from a back-pressuring consumer such as a bus writer or a result checker.

---
 rtl/fp_mult_result_fifo.sv | 103 ++++++++++
 tb/tb_fp_mult_result_fifo.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_mult_result_fifo.sv
// fp_mult_result_fifo: result FIFO behind fp_mult_top.
// Buffers (z, status) pairs in a DEPTH-entry circular buffer, presents them
// over valid/ready, counts accepted pushes (saturating) and flags drops.
// Optional macro FP_STICKY_FLAGS_EN builds the IEEE flag accumulator;
// without it sticky_flags is tied to zero.
module fp_mult_result_fifo #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic [31:0]                in_z,
    input  logic [7:0]                 in_status,
    output logic                       in_ready,
    output logic                       out_valid,
    output logic [31:0]                out_z,
    output logic [7:0]                 out_status,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH):0]     count,
    output logic [CNT_W-1:0]           result_cnt,
    output logic                       overflow,
    input  logic                       flags_clr,
    output logic [5:0]                 sticky_flags
);
    localparam int AW = $clog2(DEPTH);

    typedef struct packed {
        logic [31:0] z;
        logic [7:0]  status;
    } entry_t;

    entry_t          mem [DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic            full, push, pop, drop;

    assign full      = (count == (AW+1)'(DEPTH));
    // A pop on a full FIFO frees the slot in the same cycle.
    assign in_ready  = !full || out_ready;
    assign out_valid = (count != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign drop      = in_valid && !in_ready;

    assign out_z      = mem[rd_ptr].z;
    assign out_status = mem[rd_ptr].status;

    // Storage write; contents intentionally survive reset.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= '{z: in_z, status: in_status};
    end

    // Pointers and occupancy; pointers wrap naturally at DEPTH (power of two).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Accepted-result counter (saturating) and sticky drop flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            result_cnt <= '0;
            overflow   <= 1'b0;
        end else if (flags_clr) begin
            result_cnt <= push ? CNT_W'(1) : '0;
            overflow   <= drop;
        end else begin
            if (push && (result_cnt != '1)) result_cnt <= result_cnt + 1'b1;
            if (drop) overflow <= 1'b1;
        end
    end

`ifdef FP_STICKY_FLAGS_EN
    logic [5:0] flags_q;

    // OR of exception flags over accepted pushes; clear restarts from this push.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            flags_q <= '0;
        end else if (flags_clr) begin
            flags_q <= push ? in_status[5:0] : 6'h0;
        end else if (push) begin
            flags_q <= flags_q | in_status[5:0];
        end
    end

    assign sticky_flags = flags_q;
`else
    assign sticky_flags = 6'h0;
`endif

endmodule

// File: tb/tb_fp_mult_result_fifo.sv
// Self-checking bench for fp_mult_result_fifo: directed table, hand-written
// corner sequences and randomized traffic against a queue-based model.
module tb_fp_mult_result_fifo;
    localparam int DEPTH = 4;
    localparam int CNT_W = 3;
    localparam int CMAX  = (1 << CNT_W) - 1;
`ifdef FP_STICKY_FLAGS_EN
    localparam bit STK = 1'b1;
`else
    localparam bit STK = 1'b0;
`endif

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   in_valid, out_ready, flags_clr;
    logic [31:0]            in_z;
    logic [7:0]             in_status;
    logic                   in_ready, out_valid, overflow;
    logic [31:0]            out_z;
    logic [7:0]             out_status;
    logic [$clog2(DEPTH):0] count;
    logic [CNT_W-1:0]       result_cnt;
    logic [5:0]             sticky_flags;

    fp_mult_result_fifo #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_z(in_z),
        .in_status(in_status), .in_ready(in_ready), .out_valid(out_valid),
        .out_z(out_z), .out_status(out_status), .out_ready(out_ready),
        .count(count), .result_cnt(result_cnt), .overflow(overflow),
        .flags_clr(flags_clr), .sticky_flags(sticky_flags)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: queue of {z,status}, plain counters.
    logic [39:0] mq[$];
    int          m_rcnt;
    bit          m_ovf;
    logic [5:0]  m_stk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_rcnt = 0;
        m_ovf  = 1'b0;
        m_stk  = 6'h0;
    endtask

    task automatic check_model();
        chk("count", 32'(count), 32'(mq.size()));
        chk("in_ready", 32'(in_ready), 32'((mq.size() != DEPTH) || out_ready));
        chk("out_valid", 32'(out_valid), 32'(mq.size() != 0));
        if (mq.size() != 0) begin
            chk("out_z", out_z, mq[0][39:8]);
            chk("out_status", 32'(out_status), 32'(mq[0][7:0]));
        end
        chk("result_cnt", 32'(result_cnt), 32'(m_rcnt));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("sticky_flags", 32'(sticky_flags), STK ? 32'(m_stk) : 32'h0);
    endtask

    // Advance one clock edge and apply the same edge to the model.
    task automatic clock_model();
        bit psh, pp, drp;
        @(posedge clk);
        if (!rst) begin
            model_reset();
        end else begin
            psh = in_valid && ((mq.size() < DEPTH) || out_ready);
            pp  = out_ready && (mq.size() != 0);
            drp = in_valid && !psh;
            if (pp)  void'(mq.pop_front());
            if (psh) mq.push_back({in_z, in_status});
            if (flags_clr) begin
                m_rcnt = psh ? 1 : 0;
                m_ovf  = drp;
                m_stk  = psh ? in_status[5:0] : 6'h0;
            end else begin
                if (psh && m_rcnt < CMAX) m_rcnt++;
                if (drp) m_ovf = 1'b1;
                if (psh) m_stk = m_stk | in_status[5:0];
            end
        end
        @(negedge clk);
    endtask

    task automatic drive(input logic iv, input logic [31:0] z, input logic [7:0] st,
                         input logic ordy, input logic clr);
        in_valid  = iv;
        in_z      = z;
        in_status = st;
        out_ready = ordy;
        flags_clr = clr;
    endtask

    task automatic step(input logic iv, input logic [31:0] z, input logic [7:0] st,
                        input logic ordy, input logic clr);
        drive(iv, z, st, ordy, clr);
        #1;
        check_model();
        clock_model();
    endtask

    // Directed vector: inputs for one cycle and expected pre-edge outputs.
    typedef struct {
        logic        iv;
        logic [31:0] z;
        logic [7:0]  st;
        logic        ordy;
        logic        clr;
        int          e_cnt;
        logic        e_rdy;
        logic        e_vld;
        logic [31:0] e_z;
        logic        e_ovf;
        int          e_rcnt;
    } vec_t;

    function automatic vec_t mk(logic iv, logic [31:0] z, logic ordy, logic clr, int e_cnt,
                                logic e_rdy, logic e_vld, logic [31:0] e_z, logic e_ovf, int e_rcnt);
        vec_t v;
        v.iv = iv; v.z = z; v.st = 8'h00; v.ordy = ordy; v.clr = clr;
        v.e_cnt = e_cnt; v.e_rdy = e_rdy; v.e_vld = e_vld; v.e_z = e_z;
        v.e_ovf = e_ovf; v.e_rcnt = e_rcnt;
        return v;
    endfunction

    vec_t vt[12];

    initial begin
        // pass-through, then clear-with-push, fill, drop, drain in order
        vt[0]  = mk(1, 32'h3F800000, 1, 0, 0, 1, 0, 32'h0,        0, 0);
        vt[1]  = mk(0, 32'h0,        1, 0, 1, 1, 1, 32'h3F800000, 0, 1);
        vt[2]  = mk(1, 32'h00000001, 0, 1, 0, 1, 0, 32'h0,        0, 1);
        vt[3]  = mk(1, 32'h00000002, 0, 0, 1, 1, 1, 32'h00000001, 0, 1);
        vt[4]  = mk(1, 32'h00000003, 0, 0, 2, 1, 1, 32'h00000001, 0, 2);
        vt[5]  = mk(1, 32'h00000004, 0, 0, 3, 1, 1, 32'h00000001, 0, 3);
        vt[6]  = mk(1, 32'h7FC00000, 0, 0, 4, 0, 1, 32'h00000001, 0, 4);
        vt[7]  = mk(0, 32'h0,        1, 0, 4, 1, 1, 32'h00000001, 1, 4);
        vt[8]  = mk(0, 32'h0,        1, 0, 3, 1, 1, 32'h00000002, 1, 4);
        vt[9]  = mk(0, 32'h0,        1, 0, 2, 1, 1, 32'h00000003, 1, 4);
        vt[10] = mk(0, 32'h0,        1, 0, 1, 1, 1, 32'h00000004, 1, 4);
        vt[11] = mk(0, 32'h0,        0, 0, 0, 1, 0, 32'h0,        1, 4);

        rst = 1'b0;
        drive(0, 32'h0, 8'h0, 0, 0);
        model_reset();
        #1;
        chk("rst_count", 32'(count), 32'h0);
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_in_ready", 32'(in_ready), 32'h1);
        chk("rst_overflow", 32'(overflow), 32'h0);
        chk("rst_result_cnt", 32'(result_cnt), 32'h0);
        chk("rst_sticky", 32'(sticky_flags), 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 12; i++) begin
            drive(vt[i].iv, vt[i].z, vt[i].st, vt[i].ordy, vt[i].clr);
            #1;
            chk($sformatf("vec%0d_count", i), 32'(count), 32'(vt[i].e_cnt));
            chk($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'(vt[i].e_rdy));
            chk($sformatf("vec%0d_out_valid", i), 32'(out_valid), 32'(vt[i].e_vld));
            if (vt[i].e_vld) chk($sformatf("vec%0d_out_z", i), out_z, vt[i].e_z);
            chk($sformatf("vec%0d_overflow", i), 32'(overflow), 32'(vt[i].e_ovf));
            chk($sformatf("vec%0d_result_cnt", i), 32'(result_cnt), 32'(vt[i].e_rcnt));
            check_model();
            clock_model();
        end

        // Full with simultaneous push and pop across pointer wrap.
        step(0, 32'h0, 8'h0, 0, 1);
        for (int i = 0; i < DEPTH; i++) step(1, 32'hA0 + 32'(i), 8'h0, 0, 0);
        for (int i = 0; i < 6; i++) begin
            drive(1, 32'h10 + 32'(i), 8'h0, 1, 0);
            #1;
            chk("full_pp_in_ready", 32'(in_ready), 32'h1);
            chk("full_pp_count", 32'(count), 32'(DEPTH));
            check_model();
            clock_model();
        end
        chk("full_pp_overflow", 32'(overflow), 32'h0);
        for (int i = 0; i < DEPTH + 1; i++) step(0, 32'h0, 8'h0, 1, 0);

        // Sticky flags accumulation and clear-with-push.
        step(0, 32'h0, 8'h0, 1, 1);
        step(1, 32'h1, 8'h04, 1, 0);
        step(1, 32'h2, 8'h20, 1, 0);
        #1 chk("sticky_24", 32'(sticky_flags), STK ? 32'h24 : 32'h0);
        step(1, 32'h3, 8'hC1, 1, 0);
        #1 chk("sticky_25", 32'(sticky_flags), STK ? 32'h25 : 32'h0);
        step(1, 32'h4, 8'h02, 1, 1);
        #1 chk("sticky_clr_push", 32'(sticky_flags), STK ? 32'h02 : 32'h0);
        chk("rcnt_clr_push", 32'(result_cnt), 32'h1);
        step(0, 32'h0, 8'h0, 1, 0);

        // Counter saturation.
        step(0, 32'h0, 8'h0, 1, 1);
        for (int i = 0; i < 9; i++) step(1, 32'h100 + 32'(i), 8'h0, 1, 0);
        #1 chk("rcnt_sat", 32'(result_cnt), 32'(CMAX));
        step(1, 32'h200, 8'h0, 1, 0);
        step(1, 32'h201, 8'h0, 1, 0);
        #1 chk("rcnt_sat_hold", 32'(result_cnt), 32'(CMAX));
        for (int i = 0; i < DEPTH + 1; i++) step(0, 32'h0, 8'h0, 1, 0);

        // Reset mid-operation with three entries queued.
        for (int i = 0; i < 3; i++) step(1, 32'h300 + 32'(i), 8'h0, 0, 0);
        drive(0, 32'h0, 8'h0, 0, 0);
        #1 chk("pre_rst_count", 32'(count), 32'h3);
        rst = 1'b0;
        #1;
        chk("mid_rst_count", 32'(count), 32'h0);
        chk("mid_rst_out_valid", 32'(out_valid), 32'h0);
        chk("mid_rst_in_ready", 32'(in_ready), 32'h1);
        model_reset();
        clock_model();
        rst = 1'b1;
        step(1, 32'hBF800000, 8'h0, 0, 0);
        #1;
        chk("post_rst_valid", 32'(out_valid), 32'h1);
        chk("post_rst_first", out_z, 32'hBF800000);
        step(0, 32'h0, 8'h0, 1, 0);

        // Randomized traffic with varying back-pressure.
        for (int blk = 0; blk < 8; blk++) begin
            int rdy_pct;
            rdy_pct = (blk % 4) * 30 + 5;
            for (int i = 0; i < 50; i++) begin
                step($urandom_range(0, 3) != 0, $urandom, 8'($urandom_range(0, 255)),
                     $urandom_range(0, 99) < rdy_pct, $urandom_range(0, 15) == 0);
            end
        end
        for (int i = 0; i < DEPTH + 1; i++) step(0, 32'h0, 8'h0, 1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
